// File: rtl/sm4_bdo_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sm4_bdo_unpacker
// Purpose  : Buffers 128-bit SM4 result blocks in a small circular FIFO and
//            serialises each one as four 32-bit words, MS word first. An
//            inflight counter turns issue/return pulses into an issue credit,
//            and a sticky flag records any block dropped on a full FIFO.
// Revision : 1.0  initial release
// ============================================================================
module sm4_bdo_unpacker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_issue,
    input  logic [127:0] blk_in,
    input  logic         blk_in_valid,
    output logic         credit_ok,
    output logic [31:0]  dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         ovf,
    input  logic         clr_ovf
);

    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]   c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]     c_DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    logic [127:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_inflight;
    logic [1:0]         r_word_idx;
    logic               r_ovf;

    logic [127:0]       w_head;
    logic               w_full;
    logic               w_xfer;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign dout_valid = (r_count != '0);
    assign w_xfer     = dout_valid & dout_ready;
    // The final word of a block frees its slot, so a full FIFO can still
    // take a new block in that same cycle.
    assign w_pop      = w_xfer & (r_word_idx == 2'd3);
    assign w_wr       = blk_in_valid & (~w_full | w_pop);
    assign w_drop     = blk_in_valid & ~w_wr;
    assign dout_last  = dout_valid & (r_word_idx == 2'd3);
    assign ovf        = r_ovf;
    // Everything issued but not yet consumed must still fit in the FIFO.
    assign credit_ok  = ({1'b0, r_count} + {1'b0, r_inflight}) < c_DEPTH_EXT;

    // Select the current word of the head block, most significant first.
    always_comb begin
        dout = w_head[127:96];
        case (r_word_idx)
            2'd0: dout = w_head[127:96];
            2'd1: dout = w_head[95:64];
            2'd2: dout = w_head[63:32];
            2'd3: dout = w_head[31:0];
            default: dout = w_head[127:96];
        endcase
    end

    // Block storage; cleared on reset so dout reads zero while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= blk_in;
        end
    end

    // Pointers, occupancy and word index of the block being emitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_xfer) begin
                r_word_idx <= r_word_idx + 2'd1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Blocks issued to the cipher whose result has not come back yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (blk_issue && !blk_in_valid) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!blk_issue && blk_in_valid && (r_inflight != '0)) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm4_bdo_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm4_bdo_unpacker
// Purpose  : Self-checking bench for sm4_bdo_unpacker: directed scenarios and
//            random traffic against a queue-based reference model, with a
//            scoreboard monitor checking every accepted output word.
// Revision : 1.0  initial release
// ============================================================================
module tb_sm4_bdo_unpacker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_issue = 1'b0;
    logic [127:0] blk_in = '0;
    logic         blk_in_valid = 1'b0;
    logic         credit_ok;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         dout_last;
    logic         ovf;
    logic         clr_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: stored blocks, position inside head block, credits.
    logic [127:0] mq[$];
    int           m_pos = 0;
    int           m_infl = 0;
    bit           m_ovf = 1'b0;
    // Scoreboard of expected output words {last, word}.
    logic [32:0]  sb[$];

    sm4_bdo_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .blk_issue(blk_issue), .blk_in(blk_in),
        .blk_in_valid(blk_in_valid), .credit_ok(credit_ok), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int p);
        return b[127 - 32*p -: 32];
    endfunction

    // Monitor: every transfer must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", dout, 32'hxxxxxxxx);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("sb_word", dout, e[31:0]);
                chk("sb_last", {31'd0, dout_last}, {31'd0, e[32]});
            end
        end
    end

    // One clock: check visible state against the model, drive inputs,
    // advance the model, then cross the rising edge.
    task automatic cycle(input bit issue, input bit vin, input logic [127:0] blk,
                         input bit rdy, input bit clr);
        int  n;
        bit  pop, acc;
        n = mq.size();
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, n != 0});
        chk("credit_ok", {31'd0, credit_ok}, {31'd0, (n + m_infl) < DEPTH});
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        if (n != 0) begin
            chk("dout", dout, word_of(mq[0], m_pos));
            chk("dout_last", {31'd0, dout_last}, {31'd0, m_pos == 3});
        end else begin
            chk("dout_last_idle", {31'd0, dout_last}, 32'd0);
        end
        blk_issue = issue; blk_in_valid = vin; blk_in = blk;
        dout_ready = rdy;  clr_ovf = clr;
        pop = (n != 0) && rdy && (m_pos == 3);
        acc = vin && ((n < DEPTH) || pop);
        if ((n != 0) && rdy) m_pos = (m_pos + 1) % 4;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(blk);
            for (int p = 0; p < 4; p++) sb.push_back({p == 3, word_of(blk, p)});
        end
        if (vin && !acc) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        if (issue && !vin) m_infl++;
        else if (!issue && vin && m_infl > 0) m_infl--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        blk_issue = 0; blk_in_valid = 0; dout_ready = 0; clr_ovf = 0; blk_in = '0;
        mq.delete(); sb.delete();
        m_pos = 0; m_infl = 0; m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout_last", {31'd0, dout_last}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_credit_ok", {31'd0, credit_ok}, 32'd1);
        chk("rst_dout", dout, 32'd0);
    endtask

    task automatic idle(input int k, input bit rdy);
        for (int i = 0; i < k; i++) cycle(0, 0, '0, rdy, 0);
    endtask

    initial begin
        logic [127:0] kblk;
        kblk = 128'h681edf34_d206965e_86b3e94f_536e4246;
        @(posedge clk);
        #1;
        do_reset();

        // Single block streamed out with the sink always ready.
        cycle(1, 0, '0, 1, 0);
        cycle(0, 1, kblk, 1, 0);
        chk("single_w0", dout, 32'h681edf34);
        idle(4, 1);
        chk("single_drained", {31'd0, dout_valid}, 32'd0);

        // Stall on word1 for five cycles.
        cycle(0, 1, kblk, 1, 0);
        cycle(0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, '0, 0, 0);
            chk("stall_hold", dout, 32'hd206965e);
        end
        idle(4, 1);

        // Credit exhaustion and recovery.
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, 1, 0);
        chk("credit_exhausted", {31'd0, credit_ok}, 32'd0);
        cycle(0, 1, {4{32'hc0de0001}}, 1, 0);
        idle(4, 1);
        chk("credit_back", {31'd0, credit_ok}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, {4{$urandom}}, 1, 0);
        idle(16, 1);

        // Overflow: five blocks into a four-deep FIFO with the sink stalled.
        for (int i = 0; i < 5; i++) cycle(0, 1, {4{32'hb0000000 + i}}, 0, 0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        idle(16, 1);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        cycle(0, 0, '0, 1, 1);
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Full FIFO with a final-word pop and a write in the same cycle.
        for (int i = 0; i < 4; i++) cycle(0, 1, {4{32'hf0000000 + i}}, 0, 0);
        idle(3, 1);
        cycle(0, 1, {4{32'hf0000004}}, 1, 0);
        chk("full_swap_ovf", {31'd0, ovf}, 32'd0);
        chk("full_swap_still_full", {31'd0, credit_ok}, 32'd0);
        // Stream ten more blocks through a full FIFO to exercise wrap.
        for (int k = 0; k < 10; k++) begin
            idle(3, 1);
            cycle(0, 1, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
        end
        idle(20, 1);

        // Reset in the middle of a block, on word2.
        cycle(0, 1, kblk, 1, 0);
        idle(2, 1);
        chk("mid_w2", dout, 32'h86b3e94f);
        do_reset();
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit iss, vin, rdy, clr;
            iss = ($urandom_range(0, 3) == 0) && ((mq.size() + m_infl) < DEPTH);
            vin = (m_infl > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 30) == 0);
            cycle(iss, vin, {$urandom, $urandom, $urandom, $urandom}, rdy, clr);
        end
        idle(40, 1);
        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm4_bdo_unpacker.md
SM4_BDO_UNPACKER -- requirements
Module: sm4_bdo_unpacker

Interface
REQ-001 Parameter DEPTH, default 4, block FIFO depth in 128-bit entries, SHALL be a power of two from 2 to 16.
REQ-002 Parameter CNT_W, default 5, width of the count/inflight counters, SHALL be at least log2(DEPTH)+1.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 blk_issue  input  1  one-cycle pulse, one block issued into the cipher pipeline.
REQ-006 blk_in  input  128  cipher result block.
REQ-007 blk_in_valid  input  1  blk_in valid this cycle; no backpressure exists on this input.
REQ-008 credit_ok  output  1  high when one more block may be issued without any risk of overflow.
REQ-009 dout  output  32  current output word.
REQ-010 dout_valid  output  1  dout holds a valid word.
REQ-011 dout_ready  input  1  sink accepts dout.
REQ-012 dout_last  output  1  dout is word 3, the final word of its block.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 clr_ovf  input  1  clears ovf.

Function
REQ-015 Block storage SHALL be a circular FIFO of DEPTH x 128 bits, with wr_ptr, rd_ptr and a count in 0..DEPTH.
REQ-016 A write SHALL occur when blk_in_valid is high and either count<DEPTH or a block-completing pop occurs in the same cycle.
REQ-017 When blk_in_valid is high with count==DEPTH and no block-completing pop in the same cycle, the block SHALL be dropped, the FIFO left unchanged and ovf set to 1 on the next clock.
REQ-018 Words SHALL be emitted most-significant first: word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0]; a 2-bit word index selects the word.
REQ-019 dout_valid SHALL equal (count!=0); dout SHALL be the selected word of fifo[rd_ptr]; dout is combinational from registers.
REQ-020 A transfer SHALL occur when dout_valid and dout_ready are both high; each transfer increments the word index modulo 4.
REQ-021 The transfer at word index 3 is a block-completing pop: rd_ptr increments modulo DEPTH and count decrements.
REQ-022 dout_last SHALL equal dout_valid AND (word index==3).
REQ-023 The count SHALL be unchanged when a write and a block-completing pop occur in the same cycle.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 An inflight counter SHALL increment on blk_issue and decrement on blk_in_valid; it is unchanged when both occur in the same cycle and SHALL saturate at 0 (blk_in_valid with inflight==0 does not underflow).
REQ-026 credit_ok SHALL equal (count+inflight)<DEPTH, evaluated combinationally from registered values.
REQ-027 dout, dout_valid and dout_last SHALL remain stable while dout_valid is high and dout_ready is low.
REQ-028 clr_ovf SHALL clear ovf; if a drop and clr_ovf occur in the same cycle, ovf SHALL be 1 (set wins).
REQ-029 Block contents SHALL never be altered between write and final pop.
REQ-030 Latency: a block written at edge N SHALL present word0 with dout_valid=1 in the cycle after edge N when the FIFO was empty.

Reset
REQ-031 While rst_n is 0 at a clock edge, wr_ptr, rd_ptr, count, inflight and word index SHALL be 0 and ovf SHALL be 0.
REQ-032 After reset, outputs SHALL be dout_valid=0, dout_last=0, ovf=0 and credit_ok=1; dout is don't-care and SHALL be 128'd0-derived 32'd0, because storage resets to 0.
REQ-033 Reset mid-block SHALL discard partially emitted and stored blocks, with no further dout_valid until a new write.

Verification
REQ-034 Single block: blk_in=681edf34_d206965e_86b3e94f_536e4246 with dout_ready=1 -> 4 consecutive words 681edf34, d206965e, 86b3e94f, 536e4246; dout_last only on the 4th.
REQ-035 Stall: dout_ready=0 for 5 cycles at word1 -> dout held at d206965e with dout_valid=1, then resumes; no word is lost or duplicated.
REQ-036 Credit: DEPTH=4, 4 blk_issue pulses with no returns -> credit_ok=0 after the 4th; one block returns and fully drains -> credit_ok=1.
REQ-037 Overflow: 5 writes with dout_ready=0 -> ovf=1 and the 5th block is dropped; draining yields blocks 1-4 in order; clr_ovf -> ovf=0.
REQ-038 Full with simultaneous pop-last and write -> the write is accepted, count stays 4, ovf stays 0; pointer wrap is checked over 10 blocks.
REQ-039 Reset asserted during word2 of a block -> next cycle dout_valid=0, credit_ok=1 and count=0.
